// File: rtl/somatorio_seq.sv
// Sequential summation engine: adds N_TERMS unsigned operands taken one per cycle over a valid/ready stream.
// Optional macro SOMATORIO_SATURACAO_EN clamps the result to all-ones on overflow instead of wrapping.
module somatorio_seq #(
  parameter int WIDTH   = 8,
  parameter int N_TERMS = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             iniciar,
  input  logic             cancelar,
  input  logic [WIDTH-1:0] dado_in,
  input  logic             dado_valid,
  output logic             dado_ready,
  output logic [WIDTH-1:0] soma,
  output logic             ocupado,
  output logic             pronto,
  output logic             erro
);

  localparam int            CW     = $clog2(N_TERMS + 1);
  localparam logic [CW-1:0] ULTIMO = CW'(N_TERMS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COLETA = 2'd1,
    DONE   = 2'd2,
    ERRO   = 2'd3
  } estado_t;

  estado_t          estado_r;
  estado_t          estado_s;
  logic [CW-1:0]    cnt_r;
  logic             ov_r;
  logic [WIDTH-1:0] soma_r;
  logic [WIDTH:0]   soma_ext_s;
  logic [WIDTH-1:0] soma_nxt_s;
  logic             carry_s;
  logic             aceita_s;
  logic             ultimo_s;

  assign soma_ext_s = {1'b0, soma_r} + {1'b0, dado_in};
  assign carry_s    = soma_ext_s[WIDTH];
  assign aceita_s   = (estado_r == COLETA) && dado_valid && !cancelar;
  assign ultimo_s   = (cnt_r == ULTIMO);
  assign soma       = soma_r;

  // Next accumulator value: wrap, or clamp once any add has carried out
  always_comb begin
    soma_nxt_s = soma_ext_s[WIDTH-1:0];
`ifdef SOMATORIO_SATURACAO_EN
    if (ov_r || carry_s) begin
      soma_nxt_s = {WIDTH{1'b1}};
    end else begin
      soma_nxt_s = soma_ext_s[WIDTH-1:0];
    end
`endif
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_r <= IDLE;
    end else begin
      estado_r <= estado_s;
    end
  end

  // Next-state logic; cancel takes priority over a same-cycle operand
  always_comb begin
    estado_s = estado_r;
    case (estado_r)
      IDLE: begin
        if (iniciar) begin
          estado_s = COLETA;
        end else begin
          estado_s = IDLE;
        end
      end
      COLETA: begin
        if (cancelar) begin
          estado_s = IDLE;
        end else if (aceita_s && ultimo_s) begin
          estado_s = (ov_r || carry_s) ? ERRO : DONE;
        end else begin
          estado_s = COLETA;
        end
      end
      DONE:    estado_s = IDLE;
      ERRO:    estado_s = IDLE;
      default: estado_s = IDLE;
    endcase
  end

  // Outputs decode the registered state only
  always_comb begin
    dado_ready = 1'b0;
    ocupado    = 1'b1;
    pronto     = 1'b0;
    erro       = 1'b0;
    case (estado_r)
      IDLE:    ocupado    = 1'b0;
      COLETA:  dado_ready = 1'b1;
      DONE:    pronto     = 1'b1;
      ERRO:    erro       = 1'b1;
      default: ocupado    = 1'b0;
    endcase
  end

  // Accumulator, sticky overflow and term counter; result holds outside COLETA
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      soma_r <= {WIDTH{1'b0}};
      ov_r   <= 1'b0;
      cnt_r  <= {CW{1'b0}};
    end else if ((estado_r == IDLE) && iniciar) begin
      soma_r <= {WIDTH{1'b0}};
      ov_r   <= 1'b0;
      cnt_r  <= {CW{1'b0}};
    end else if (aceita_s) begin
      soma_r <= soma_nxt_s;
      ov_r   <= ov_r | carry_s;
      cnt_r  <= cnt_r + CW'(1);
    end else begin
      soma_r <= soma_r;
      ov_r   <= ov_r;
      cnt_r  <= cnt_r;
    end
  end

endmodule

// File: tb/tb_somatorio_seq.sv
// Directed and randomized bench for somatorio_seq: default instance (8-bit, 4 terms) and a 4-bit single-term instance.
module tb_somatorio_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       iniciar, cancelar, dado_valid;
  logic [7:0] dado_in;
  logic       dado_ready, ocupado, pronto, erro;
  logic [7:0] soma;

  logic       iniciar1, cancelar1, dado_valid1;
  logic [3:0] dado_in1;
  logic       dado_ready1, ocupado1, pronto1, erro1;
  logic [3:0] soma1;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] ops [4];

  always #5 clk = ~clk;

  somatorio_seq #(.WIDTH(8), .N_TERMS(4)) dut (
    .clk(clk), .reset_n(reset_n), .iniciar(iniciar), .cancelar(cancelar),
    .dado_in(dado_in), .dado_valid(dado_valid), .dado_ready(dado_ready),
    .soma(soma), .ocupado(ocupado), .pronto(pronto), .erro(erro)
  );

  somatorio_seq #(.WIDTH(4), .N_TERMS(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .iniciar(iniciar1), .cancelar(cancelar1),
    .dado_in(dado_in1), .dado_valid(dado_valid1), .dado_ready(dado_ready1),
    .soma(soma1), .ocupado(ocupado1), .pronto(pronto1), .erro(erro1)
  );

  // Expected result from the plain integer total of all accepted operands
  function automatic int modelo(input int total, input int w);
`ifdef SOMATORIO_SATURACAO_EN
    if (total >= (1 << w)) return (1 << w) - 1;
    else return total;
`else
    return total % (1 << w);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 4-term run using ops[]; 'gap' idle cycles between operands, optional iniciar poke during gaps
  task automatic run_soma(input int gap, input bit cutuca);
    int total;
    total = 0;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk("start_ocupado", ocupado, 1);
    chk("start_soma", soma, 0);
    chk("start_ready", dado_ready, 1);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        for (int j = 0; j < gap; j++) begin
          dado_valid = 1'b0;
          dado_in    = 8'($urandom);
          iniciar    = cutuca;
          tick();
          iniciar = 1'b0;
          chk("gap_soma", soma, modelo(total, 8));
          chk("gap_pulse", {pronto, erro}, 2'b00);
          chk("gap_ocupado", ocupado, 1);
        end
      end
      dado_valid = 1'b1;
      dado_in    = ops[k];
      tick();
      total += int'(ops[k]);
      chk("parcial", soma, modelo(total, 8));
    end
    dado_valid = 1'b0;
    chk("pronto", pronto, (total < 256) ? 1 : 0);
    chk("erro", erro, (total >= 256) ? 1 : 0);
    chk("fim_ready", dado_ready, 0);
    chk("fim_ocupado", ocupado, 1);
    tick();
    chk("idle_ocupado", ocupado, 0);
    chk("idle_pulse", {pronto, erro}, 2'b00);
    chk("idle_soma", soma, modelo(total, 8));
  endtask

  initial begin
    int tot1;
    reset_n = 1'b0; iniciar = 1'b0; cancelar = 1'b0; dado_valid = 1'b0; dado_in = 8'd0;
    iniciar1 = 1'b0; cancelar1 = 1'b0; dado_valid1 = 1'b0; dado_in1 = 4'd0;
    #12;
    chk("rst_soma", soma, 0);
    chk("rst_flags", {dado_ready, ocupado, pronto, erro}, 4'b0000);
    reset_n = 1'b1;
    tick();

    // Basic sum
    ops = '{8'd10, 8'd20, 8'd30, 8'd40};
    run_soma(0, 1'b0);
    // Overflow
    ops = '{8'd100, 8'd100, 8'd50, 8'd10};
    run_soma(0, 1'b0);
    // Gaps with ignored iniciar
    ops = '{8'd1, 8'd2, 8'd3, 8'd4};
    run_soma(3, 1'b1);

    // Inputs ignored while idle
    cancelar = 1'b1; dado_valid = 1'b1; dado_in = 8'd77;
    tick();
    cancelar = 1'b0; dado_valid = 1'b0;
    chk("idle_ign_ocupado", ocupado, 0);
    chk("idle_ign_soma", soma, 10);

    // Cancel together with the third operand
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    dado_valid = 1'b1; dado_in = 8'd5; tick();
    dado_in = 8'd6; tick();
    dado_in = 8'd7; cancelar = 1'b1; tick();
    cancelar = 1'b0; dado_valid = 1'b0;
    chk("cancel_ocupado", ocupado, 0);
    chk("cancel_soma", soma, 11);
    chk("cancel_pulse", {pronto, erro}, 2'b00);
    tick();
    chk("cancel_pulse2", {pronto, erro}, 2'b00);
    ops = '{8'd3, 8'd3, 8'd3, 8'd3};
    run_soma(0, 1'b0);

    // Asynchronous reset mid-run
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    dado_valid = 1'b1; dado_in = 8'd9; tick();
    dado_in = 8'd8; tick();
    dado_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_soma", soma, 0);
    chk("arst_flags", {dado_ready, ocupado, pronto, erro}, 4'b0000);
    #3 reset_n = 1'b1;
    tick();
    ops = '{8'd50, 8'd60, 8'd70, 8'd65};
    run_soma(0, 1'b0);

    // Randomized runs
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 4; k++) ops[k] = 8'($urandom_range((r % 2 == 0) ? 60 : 255, 0));
      run_soma($urandom_range(2, 0), r[0]);
    end

    // iniciar held high: one result pulse and one idle cycle every N_TERMS+2 cycles
    iniciar = 1'b1; dado_valid = 1'b1;
    for (int t = 0; t < 12; t++) begin
      dado_in = 8'($urandom_range(60, 0));
      tick();
      chk("cont_ocupado", ocupado, (t % 6 != 5) ? 1 : 0);
      chk("cont_pulse", pronto | erro, (t % 6 == 4) ? 1 : 0);
    end
    iniciar = 1'b0; dado_valid = 1'b0;
    tick();

    // Single-term 4-bit instance, repeated runs
    for (int r = 0; r < 4; r++) begin
      tot1 = (r == 0) ? 15 : int'($urandom_range(15, 0));
      iniciar1 = 1'b1; tick(); iniciar1 = 1'b0;
      chk("n1_start_soma", soma1, 0);
      dado_valid1 = 1'b1; dado_in1 = 4'(tot1); tick();
      dado_valid1 = 1'b0;
      chk("n1_pronto", pronto1, 1);
      chk("n1_erro", erro1, 0);
      chk("n1_soma", soma1, modelo(tot1, 4));
      tick();
      chk("n1_idle", ocupado1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/somatorio_seq.md
# somatorio_seq

Parametrised sequential summation engine that adds `N_TERMS` operands of `WIDTH` bits, accepted one per cycle through a valid/ready stream. It reports the result with a one-cycle `pronto` pulse, or an `erro` pulse on overflow. It supersedes the fixed four-term somatorio control path and adds generic width and term count, an input handshake that tolerates gaps, abort, and optional saturation. It sits between the operand source (register bank or FIFO) and the result consumer.

## Interface
- `WIDTH`, 8: operand and result width in bits; must be ≥ 2.
- `N_TERMS`, 4: number of operands per summation; must be ≥ 1.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `iniciar` in 1: start request; honoured only in IDLE.
- `cancelar` in 1: synchronous abort; honoured in COLETA.
- `dado_in` in WIDTH: operand, unsigned.
- `dado_valid` in 1: `dado_in` is valid this cycle.
- `dado_ready` out 1: block accepts an operand this cycle.
- `soma` out WIDTH: accumulated or final result.
- `ocupado` out 1: high in every state except IDLE.
- `pronto` out 1: one-cycle pulse; the summation finished without overflow.
- `erro` out 1: one-cycle pulse; the summation finished with overflow.

## Operation
- **States:** IDLE, COLETA, DONE, ERRO. The state register, term counter (`$clog2(N_TERMS+1)` bits), accumulator and sticky overflow flag `ov` are all registered.
- **IDLE:**
  - `iniciar=1` causes the next state to be COLETA.
  - On that same edge: `soma` is cleared to 0, `ov` is cleared to 0, and the counter is cleared to 0.
- **COLETA:**
  - `dado_ready=1`.
  - An operand is accepted on any edge where `dado_valid && dado_ready && !cancelar`.
  - On acceptance: `soma` takes the sum as a WIDTH+1-bit value truncated to WIDTH bits, the carry-out is ORed into `ov`, and the counter increments.
  - When `dado_valid=0`, nothing changes; gaps are unlimited.
- **Last operand:** on acceptance of operand number N_TERMS, the next state is ERRO if (`ov` OR the carry of this add), otherwise DONE.
- **DONE:** `pronto=1` for exactly one cycle, then IDLE.
- **ERRO:** `erro=1` for exactly one cycle, then IDLE.
- **Result hold:** `soma` keeps the final value through DONE/ERRO and IDLE until the next accepted `iniciar`.
- **Abort:** `cancelar=1` in COLETA returns to IDLE on the next edge.
  - No `pronto` or `erro` is produced.
  - `soma` keeps its partial value.
  - `cancelar` wins over a simultaneous valid operand; that operand is not accepted.
- **Ignored inputs:**
  - `iniciar` outside IDLE is ignored.
  - `cancelar` outside COLETA is ignored.
  - `dado_valid` outside COLETA is ignored, and `dado_ready=0` there.
- **Async reset** (`reset_n=0`), at any time including mid-summation:
  - state returns to IDLE;
  - `soma=0`, `ov=0`, counter = 0;
  - `dado_ready=0`, `ocupado=0`, `pronto=0`, `erro=0`.

## Timing
- **Back-to-back latency, with `dado_valid` held high:**
  - `iniciar` is sampled at edge 0;
  - operands are accepted at edges 1..N_TERMS;
  - `pronto`/`erro` is high during the cycle after edge N_TERMS;
  - IDLE is re-entered at edge N_TERMS+1.
- **Restart:** minimum spacing between two accepted `iniciar` is N_TERMS+2 cycles; `iniciar` may be held high continuously.
- **Output registering:** `dado_ready`, `ocupado`, `pronto` and `erro` decode the registered state only, with no input-to-output combinational path. `soma` is registered.
- **Partial sums:** `soma` is valid partial-sum data during COLETA, updated one cycle after each acceptance.

## Configuration
- **`SOMATORIO_SATURACAO_EN` defined:**
  - When any add carries out, `soma` is forced to all-ones (2^WIDTH−1) and remains there for the rest of the summation.
  - Later adds do not wrap.
  - `erro` is still pulsed at the end.
- **Not defined:** `soma` wraps modulo 2^WIDTH; `erro` behaviour is identical.

## Test plan
Defaults (WIDTH=8, N_TERMS=4) unless a scenario states otherwise.
- **Basic sum:** `iniciar` pulse, then operands 10, 20, 30, 40 with valid held high -> `pronto` high in cycle 5, `soma`=100, `erro`=0, `ocupado` high in cycles 1–5.
- **Overflow:** operands 100, 100, 50, 10 -> `erro` pulse in cycle 5, `pronto`=0.
  - Without the macro: `soma`=4.
  - With `SOMATORIO_SATURACAO_EN`: `soma`=255.
- **Gaps and ignored start:**
  - Operands 1, 2, 3, 4 with `dado_valid` low for 3 cycles between each -> `pronto` in cycle 14, `soma`=10.
  - `iniciar` pulsed mid-run is ignored.
- **Cancel:** `cancelar` asserted together with the third valid operand (after 5, 6) -> IDLE next cycle, no `pronto`/`erro`, `soma`=11.
  - A following `iniciar` restarts from 0.
- **Reset mid-run:** `reset_n` pulled low asynchronously between edges after 2 operands -> all outputs 0 immediately.
  - After release, a normal 4-term run succeeds.
- **Edge case:** N_TERMS=1, WIDTH=4, operand 15 -> `pronto` in cycle 2, `soma`=15.
  - A repeated run with `ov` from a prior run does not leak into the new run.
